// File: rtl/stream_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pattern_pkg
// Brief    : Modes, FSM state encodings and the sequence step function shared
//            by the stream pattern driver and its generators.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pattern_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_DEC   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    // Generators zero-extend into this width and truncate the result back.
    localparam int GEN_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_GAP      = 3'd3,
        ST_FIN      = 3'd4
    } state_t;

    function automatic logic [GEN_W-1:0] next_val(
        input logic [1:0]       mode,
        input logic [GEN_W-1:0] v,
        input logic [GEN_W-1:0] poly
    );
        logic [GEN_W-1:0] nv;
        nv = v;
        case (mode)
            MODE_INC:  nv = v + GEN_W'(1);
            MODE_DEC:  nv = v - GEN_W'(1);
            MODE_LFSR: nv = v[0] ? ((v >> 1) ^ poly) : (v >> 1);
            default:   nv = v;
        endcase
        return nv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pattern_driver_gen.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen
// Brief    : Sequence generator (inc/dec/LFSR/const) with load and step.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen #(
    parameter int            DW    = 8,
    parameter logic [DW-1:0] START = 8'h53,
    parameter logic [DW-1:0] POLY  = 8'hB8
) (
    input  logic          tb_clk,
    input  logic          tb_rst,
    input  logic          load,
    input  logic          step,
    input  logic [1:0]    mode,
    output logic [DW-1:0] value
);
    import stream_pattern_pkg::*;

    // An all-zero LFSR would lock up, so a zero seed becomes 1 in that mode.
    localparam logic [DW-1:0] c_lfsr_seed = (START == '0) ? DW'(1) : START;

    logic [DW-1:0] r_val;
    logic [DW-1:0] w_seed;
    logic [DW-1:0] w_next;

    assign w_seed = (mode == MODE_LFSR) ? c_lfsr_seed : START;
    assign w_next = DW'(next_val(mode, GEN_W'(r_val), GEN_W'(POLY)));

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_val <= START;
        end else if (load) begin
            r_val <= w_seed;
        end else if (step) begin
            r_val <= w_next;
        end
    end

    assign value = r_val;

endmodule
`default_nettype wire

// File: rtl/stream_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : stream_pattern_driver
// Brief    : Pattern stream source with handshake pacing plus a return-path
//            checker that regenerates the sequence and counts mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module stream_pattern_driver #(
    parameter int            DW     = 8,
    parameter int            CW     = 16,
    parameter logic [DW-1:0] START  = 8'h53,
    parameter int            NWORDS = 167,
    parameter int            GAP    = 1,
    parameter logic [DW-1:0] POLY   = 8'hB8
) (
    input  logic          tb_clk,
    input  logic          tb_rst,
    input  logic          enable,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [DW-1:0] src_dat,
    output logic          src_stb,
    input  logic          src_ack,
    input  logic [DW-1:0] chk_dat,
    input  logic          chk_stb,
    output logic          chk_ack,
    output logic [CW-1:0] sent_cnt,
    output logic [CW-1:0] chk_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          busy,
    output logic          done
);
    import stream_pattern_pkg::*;

    localparam int              c_gap      = (GAP < 1) ? 1 : GAP;
    localparam int              c_gw       = (c_gap > 1) ? $clog2(c_gap) : 1;
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(c_gap - 1);
    localparam logic [CW-1:0]   c_nwords   = CW'(NWORDS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_mode;
    logic [DW-1:0]   r_src_dat;
    logic [CW-1:0]   r_sent;
    logic [CW-1:0]   r_chk;
    logic [CW-1:0]   r_err;
    logic [c_gw-1:0] r_gap;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_gen_mode;
    logic [DW-1:0]   w_src_val;
    logic [DW-1:0]   w_exp_val;
    logic            w_accept;
    logic            w_last;
    logic            w_check;
    logic            w_fin_done;

    // Generators load with the incoming mode on start, then follow the latched one.
    assign w_gen_mode = start ? mode : r_mode;
    assign w_accept   = (r_state == ST_WAIT_ACK) && enable && src_ack && !start;
    assign w_last     = (r_sent + CW'(1)) == c_nwords;
    assign w_check    = chk_stb && r_busy && (r_chk != c_nwords) && !start;
    assign w_fin_done = (r_state == ST_FIN) && (r_chk == c_nwords);

    pattern_gen #(.DW(DW), .START(START), .POLY(POLY)) u_src_gen (
        .tb_clk (tb_clk),
        .tb_rst (tb_rst),
        .load   (start),
        .step   (w_accept),
        .mode   (w_gen_mode),
        .value  (w_src_val)
    );

    pattern_gen #(.DW(DW), .START(START), .POLY(POLY)) u_exp_gen (
        .tb_clk (tb_clk),
        .tb_rst (tb_rst),
        .load   (start),
        .step   (w_check),
        .mode   (w_gen_mode),
        .value  (w_exp_val)
    );

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_SEND;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = ST_IDLE;
                ST_SEND:     if (enable) w_state_nxt = ST_WAIT_ACK;
                ST_WAIT_ACK: if (w_accept) w_state_nxt = w_last ? ST_FIN : ST_GAP;
                ST_GAP:      if (r_gap == '0) w_state_nxt = ST_SEND;
                ST_FIN:      if (w_fin_done) w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_mode    <= MODE_INC;
            r_src_dat <= '0;
            r_sent    <= '0;
            r_chk     <= '0;
            r_err     <= '0;
            r_gap     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_mode <= mode;
            r_sent <= '0;
            r_chk  <= '0;
            r_err  <= '0;
            r_gap  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else begin
            if ((r_state == ST_SEND) && enable) begin
                r_src_dat <= w_src_val;
            end
            if (w_accept) begin
                r_sent <= (r_sent == '1) ? r_sent : r_sent + CW'(1);
                r_gap  <= c_gap_last;
            end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
                r_gap <= r_gap - c_gw'(1);
            end
            if (w_check) begin
                r_chk <= (r_chk == '1) ? r_chk : r_chk + CW'(1);
                if ((chk_dat != w_exp_val) && (r_err != '1)) begin
                    r_err <= r_err + CW'(1);
                end
            end
            if (w_fin_done) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    // Strobe is gated combinationally so enable-low and abort take effect at once.
    assign src_stb  = (r_state == ST_WAIT_ACK) && enable && !start;
    assign src_dat  = r_src_dat;
    assign chk_ack  = chk_stb;
    assign sent_cnt = r_sent;
    assign chk_cnt  = r_chk;
    assign err_cnt  = r_err;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stream_pattern_driver.sv
`default_nettype none
// Bench for stream_pattern_driver: three parameterisations driven from a run
// table with randomized handshakes, plus hand-written abort and reset sequences.
module tb_stream_pattern_driver;
    localparam int NI = 3;
    localparam int c_budget = 6000;

    logic       tb_clk = 1'b0;
    logic       tb_rst;
    logic       enable   [NI];
    logic       start    [NI];
    logic [1:0] mode     [NI];
    logic [7:0] src_dat  [NI];
    logic       src_stb  [NI];
    logic       src_ack  [NI];
    logic [7:0] chk_dat  [NI];
    logic       chk_stb  [NI];
    logic       chk_ack  [NI];
    logic [15:0] sent_cnt[NI];
    logic [15:0] chk_cnt [NI];
    logic [15:0] err_cnt [NI];
    logic       busy     [NI];
    logic       done     [NI];

    always #5 tb_clk = ~tb_clk;

    stream_pattern_driver u_dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst), .enable(enable[0]), .start(start[0]), .mode(mode[0]),
        .src_dat(src_dat[0]), .src_stb(src_stb[0]), .src_ack(src_ack[0]), .chk_dat(chk_dat[0]),
        .chk_stb(chk_stb[0]), .chk_ack(chk_ack[0]), .sent_cnt(sent_cnt[0]), .chk_cnt(chk_cnt[0]),
        .err_cnt(err_cnt[0]), .busy(busy[0]), .done(done[0]));

    stream_pattern_driver #(.START(8'h02), .NWORDS(5)) u_dec (
        .tb_clk(tb_clk), .tb_rst(tb_rst), .enable(enable[1]), .start(start[1]), .mode(mode[1]),
        .src_dat(src_dat[1]), .src_stb(src_stb[1]), .src_ack(src_ack[1]), .chk_dat(chk_dat[1]),
        .chk_stb(chk_stb[1]), .chk_ack(chk_ack[1]), .sent_cnt(sent_cnt[1]), .chk_cnt(chk_cnt[1]),
        .err_cnt(err_cnt[1]), .busy(busy[1]), .done(done[1]));

    stream_pattern_driver #(.START(8'h00), .NWORDS(5), .GAP(0)) u_lfsr (
        .tb_clk(tb_clk), .tb_rst(tb_rst), .enable(enable[2]), .start(start[2]), .mode(mode[2]),
        .src_dat(src_dat[2]), .src_stb(src_stb[2]), .src_ack(src_ack[2]), .chk_dat(chk_dat[2]),
        .chk_stb(chk_stb[2]), .chk_ack(chk_ack[2]), .sent_cnt(sent_cnt[2]), .chk_cnt(chk_cnt[2]),
        .err_cnt(err_cnt[2]), .busy(busy[2]), .done(done[2]));

    typedef struct { int k; logic [7:0] dat; int due; } ret_t;
    typedef struct {
        int k; logic [1:0] m; int ack; int extra; int ea; int eb; int corr; bit st;
        logic [7:0] w0; logic [7:0] w1; int ns; int nc; int ne;
    } vec_t;

    ret_t       rq[$];
    vec_t       vecs[8];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         now = 0;
    int         cyc[NI], nacc[NI], last_acc[NI], ack_pct[NI], ret_extra[NI];
    int         en_a[NI], en_b[NI], corrupt_idx[NI];
    bit         strict[NI];
    logic       start_req[NI];
    logic [1:0] run_mode[NI];
    logic [7:0] held_dat[NI], seen0[NI], seen1[NI];

    function automatic logic [7:0] start_of(input int k);
        return (k == 0) ? 8'h53 : (k == 1) ? 8'h02 : 8'h00;
    endfunction

    // n-th word of a run, straight from the sequence definitions.
    function automatic logic [7:0] model_word(input int k, input logic [1:0] m, input int n);
        logic [7:0] v;
        v = start_of(k);
        case (m)
            2'd0: return 8'((int'(v) + n) % 256);
            2'd1: return 8'((int'(v) - n + 256 * 64) % 256);
            2'd3: return v;
            default: begin
                if (v == 8'h00) v = 8'h01;
                for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
                return v;
            end
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic flush(input int k);
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].k == k) rq.delete(i);
    endtask

    task automatic cycle();
        ret_t e;
        @(negedge tb_clk);
        now++;
        for (int k = 0; k < NI; k++) begin
            start[k] = start_req[k];
            start_req[k] = 1'b0;
            if (start[k]) begin
                cyc[k] = 0; nacc[k] = 0; last_acc[k] = 0;
            end else begin
                cyc[k]++;
                mode[k] = 2'($urandom_range(3));
            end
            enable[k]  = !(cyc[k] >= en_a[k] && cyc[k] <= en_b[k]);
            src_ack[k] = ($urandom_range(99) < ack_pct[k]);
            chk_stb[k] = 1'b0;
            chk_dat[k] = 8'($urandom);
            for (int i = 0; i < rq.size(); i++) begin
                if (rq[i].k == k) begin
                    if (rq[i].due <= now) begin
                        chk_stb[k] = 1'b1;
                        chk_dat[k] = rq[i].dat;
                        rq.delete(i);
                    end
                    break;
                end
            end
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            if (chk_stb[k]) check("chk_ack", k, 32'(chk_ack[k]), 32'd1);
            if (!enable[k] && cyc[k] > en_a[k]) begin
                check("stb_in_window", k, 32'(src_stb[k]), 32'd0);
                check("dat_held", k, 32'(src_dat[k]), 32'(held_dat[k]));
            end else if (!enable[k]) begin
                held_dat[k] = src_dat[k];
            end
            if (src_stb[k] && src_ack[k]) begin
                check("word", k, 32'(src_dat[k]), 32'(model_word(k, run_mode[k], nacc[k])));
                if (strict[k]) check("spacing", k, 32'(cyc[k] - last_acc[k]), (nacc[k] == 0) ? 32'd2 : 32'd3);
                if (nacc[k] == 0) seen0[k] = src_dat[k];
                if (nacc[k] == 1) seen1[k] = src_dat[k];
                e.k   = k;
                e.dat = src_dat[k] ^ ((nacc[k] == corrupt_idx[k]) ? 8'h01 : 8'h00);
                e.due = now + 3 + int'($urandom_range(ret_extra[k]));
                rq.push_back(e);
                nacc[k]++;
                last_acc[k] = cyc[k];
            end
        end
    endtask

    task automatic start_run(input int k, input logic [1:0] m, input int ack, input int extra,
                             input int ea, input int eb, input int corr, input bit st);
        flush(k);
        run_mode[k] = m; mode[k] = m; ack_pct[k] = ack; ret_extra[k] = extra;
        en_a[k] = ea; en_b[k] = eb; corrupt_idx[k] = corr; strict[k] = st;
        seen0[k] = 8'h00; seen1[k] = 8'h00;
        start_req[k] = 1'b1;
        cycle();
    endtask

    task automatic finish_run(input int k, input string tag, input logic [7:0] w0, input logic [7:0] w1,
                              input int ns, input int nc, input int ne);
        int i;
        i = 0;
        while (!(done[k] && cyc[k] > 0) && i < c_budget) begin
            cycle();
            i++;
        end
        check({tag, ".done"}, k, 32'(done[k]), 32'd1);
        check({tag, ".busy"}, k, 32'(busy[k]), 32'd0);
        check({tag, ".sent_cnt"}, k, 32'(sent_cnt[k]), 32'(ns));
        check({tag, ".chk_cnt"}, k, 32'(chk_cnt[k]), 32'(nc));
        check({tag, ".err_cnt"}, k, 32'(err_cnt[k]), 32'(ne));
        check({tag, ".words_seen"}, k, 32'(nacc[k]), 32'(ns));
        check({tag, ".word0"}, k, 32'(seen0[k]), 32'(w0));
        check({tag, ".word1"}, k, 32'(seen1[k]), 32'(w1));
    endtask

    task automatic run_to_word(input int k, input int n);
        int i;
        i = 0;
        while (nacc[k] < n && i < c_budget) begin
            cycle();
            i++;
        end
        check("reach_word", k, 32'(nacc[k]), 32'(n));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            enable[k] = 1'b1; start[k] = 1'b0; mode[k] = 2'd0; src_ack[k] = 1'b0;
            chk_dat[k] = 8'h00; chk_stb[k] = 1'b0; start_req[k] = 1'b0;
            cyc[k] = 0; nacc[k] = 0; last_acc[k] = 0; ack_pct[k] = 100; ret_extra[k] = 0;
            en_a[k] = -1; en_b[k] = -2; corrupt_idx[k] = -1; strict[k] = 1'b0;
            run_mode[k] = 2'd0; held_dat[k] = 8'h00; seen0[k] = 8'h00; seen1[k] = 8'h00;
        end
        //          k  mode  ack extra  ea    eb  corr st   w0     w1    sent chk err
        vecs[0] = '{0, 2'd0, 100, 0,    -1,   -2,  -1, 1, 8'h53, 8'h54, 167, 167, 0};
        vecs[1] = '{0, 2'd0, 100, 0,    50, 2049,  -1, 0, 8'h53, 8'h54, 167, 167, 0};
        vecs[2] = '{1, 2'd1, 100, 0,    -1,   -2,  -1, 1, 8'h02, 8'h01,   5,   5, 0};
        vecs[3] = '{2, 2'd2, 100, 0,    -1,   -2,  -1, 1, 8'h01, 8'hB8,   5,   5, 0};
        vecs[4] = '{0, 2'd0, 100, 0,    -1,   -2,  10, 1, 8'h53, 8'h54, 167, 167, 1};
        vecs[5] = '{0, 2'd2,  40, 4,   100,  160,  -1, 0, 8'h53, 8'h91, 167, 167, 0};
        vecs[6] = '{0, 2'd1,  60, 2,    -1,   -2,  37, 0, 8'h53, 8'h52, 167, 167, 1};
        vecs[7] = '{1, 2'd3,  50, 3,     3,    9,  -1, 0, 8'h02, 8'h02,   5,   5, 0};

        tb_rst = 1'b1;
        repeat (3) cycle();
        for (int k = 0; k < NI; k++) begin
            check("rst.src_stb", k, 32'(src_stb[k]), 32'd0);
            check("rst.src_dat", k, 32'(src_dat[k]), 32'd0);
            check("rst.sent_cnt", k, 32'(sent_cnt[k]), 32'd0);
            check("rst.chk_cnt", k, 32'(chk_cnt[k]), 32'd0);
            check("rst.err_cnt", k, 32'(err_cnt[k]), 32'd0);
            check("rst.busy", k, 32'(busy[k]), 32'd0);
            check("rst.done", k, 32'(done[k]), 32'd0);
        end
        tb_rst = 1'b0;
        cycle();

        for (int v = 0; v < 8; v++) begin
            start_run(vecs[v].k, vecs[v].m, vecs[v].ack, vecs[v].extra, vecs[v].ea, vecs[v].eb,
                      vecs[v].corr, vecs[v].st);
            finish_run(vecs[v].k, $sformatf("vec%0d", v), vecs[v].w0, vecs[v].w1,
                       vecs[v].ns, vecs[v].nc, vecs[v].ne);
        end

        // Abort with start while a word is pending and ack is high in the same cycle.
        start_run(0, 2'd0, 100, 0, -1, -2, -1, 1'b1);
        run_to_word(0, 20);
        ack_pct[0] = 0;
        repeat (3) cycle();
        check("abort.stb_pending", 0, 32'(src_stb[0]), 32'd1);
        start_run(0, 2'd0, 100, 0, -1, -2, -1, 1'b1);
        check("abort.stb_drop", 0, 32'(src_stb[0]), 32'd0);
        check("abort.nacc", 0, 32'(nacc[0]), 32'd0);
        cycle();
        check("abort.sent_clr", 0, 32'(sent_cnt[0]), 32'd0);
        check("abort.chk_clr", 0, 32'(chk_cnt[0]), 32'd0);
        check("abort.busy", 0, 32'(busy[0]), 32'd1);
        check("abort.done", 0, 32'(done[0]), 32'd0);
        finish_run(0, "abort", 8'h53, 8'h54, 167, 167, 0);

        // Asynchronous reset mid-run, then idle until the next start.
        start_run(0, 2'd0, 100, 0, -1, -2, -1, 1'b1);
        run_to_word(0, 20);
        ack_pct[0] = 0;
        repeat (3) cycle();
        check("rst_mid.stb_pending", 0, 32'(src_stb[0]), 32'd1);
        #1 tb_rst = 1'b1;
        #1;
        check("rst_mid.src_stb", 0, 32'(src_stb[0]), 32'd0);
        check("rst_mid.src_dat", 0, 32'(src_dat[0]), 32'd0);
        check("rst_mid.sent_cnt", 0, 32'(sent_cnt[0]), 32'd0);
        check("rst_mid.busy", 0, 32'(busy[0]), 32'd0);
        repeat (2) cycle();
        flush(0);
        tb_rst = 1'b0;
        ack_pct[0] = 100;
        strict[0] = 1'b0;
        repeat (5) begin
            cycle();
            check("rst_mid.idle_stb", 0, 32'(src_stb[0]), 32'd0);
        end
        check("rst_mid.idle_busy", 0, 32'(busy[0]), 32'd0);
        start_run(0, 2'd0, 100, 0, -1, -2, -1, 1'b1);
        finish_run(0, "rst_restart", 8'h53, 8'h54, 167, 167, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
